// File: rtl/extram_arb_pkg.sv
// Shared definitions for the external SRAM arbiter: FSM states, grant IDs,
// bus widths and the request bundle captured at grant time.
package extram_arb_pkg;

    localparam int EXTRAM_AW = 16;
    localparam int EXTRAM_DW = 32;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_e;

    localparam logic GNT_M0 = 1'b0;
    localparam logic GNT_M1 = 1'b1;

    // One requester's access as seen by the SRAM side.
    typedef struct packed {
        logic [EXTRAM_AW-1:0] addr;
        logic [EXTRAM_DW-1:0] wdata;
        logic [3:0]           wstrb;
    } ext_req_t;

    // Wait counter width; never narrower than one bit so WAIT_STATES=0 still works.
    function automatic int cnt_width(input int ws);
        if (ws < 1) begin
            return 1;
        end else begin
            return $clog2(ws + 1);
        end
    endfunction

endpackage

// File: rtl/extram_arbiter_rr_arb2.sv
// Two-way round-robin picker. Purely combinational; the caller keeps the
// identity of the previous winner and feeds it back on last_grant.
module rr_arb2
    import extram_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       gnt_valid,
    output logic       gnt_id
);

    // Single requester wins outright; on a tie the one that did not win last time goes.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_id    = GNT_M0;
        case (req)
            2'b01: begin
                gnt_valid = 1'b1;
                gnt_id    = GNT_M0;
            end
            2'b10: begin
                gnt_valid = 1'b1;
                gnt_id    = GNT_M1;
            end
            2'b11: begin
                gnt_valid = 1'b1;
                gnt_id    = ~last_grant;
            end
            default: begin
                gnt_valid = 1'b0;
                gnt_id    = GNT_M0;
            end
        endcase
    end

endmodule

// File: rtl/extram_arbiter.sv
// Shares one external SRAM port between two 32-bit requesters. Each access is
// granted round-robin in IDLE, held on the bus for WAIT_STATES+1 cycles, and
// completed with a one-cycle ready pulse in DONE. Every bus output is a flop.
module extram_arbiter
    import extram_arb_pkg::*;
#(
    parameter int WAIT_STATES = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 m0_valid,
    input  logic [EXTRAM_AW-1:0] m0_addr,
    input  logic [EXTRAM_DW-1:0] m0_wdata,
    input  logic [3:0]           m0_wstrb,
    output logic [EXTRAM_DW-1:0] m0_rdata,
    output logic                 m0_ready,
    input  logic                 m1_valid,
    input  logic [EXTRAM_AW-1:0] m1_addr,
    input  logic [EXTRAM_DW-1:0] m1_wdata,
    input  logic [3:0]           m1_wstrb,
    output logic [EXTRAM_DW-1:0] m1_rdata,
    output logic                 m1_ready,
    output logic [EXTRAM_AW-1:0] extram_a,
    output logic [EXTRAM_DW-1:0] extram_d_out,
    input  logic [EXTRAM_DW-1:0] extram_d_in,
    output logic                 extram_cs,
    output logic                 extram_oe,
    output logic [3:0]           extram_wstrb
);

    localparam int            CW       = cnt_width(WAIT_STATES);
    localparam logic [CW-1:0] CNT_LOAD = CW'(WAIT_STATES);

    state_e               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 last_q, last_d;
    logic [EXTRAM_AW-1:0] a_q, a_d;
    logic [EXTRAM_DW-1:0] dout_q, dout_d;
    logic [3:0]           wstrb_q, wstrb_d;
    logic                 cs_q, cs_d;
    logic                 oe_q, oe_d;
    logic [EXTRAM_DW-1:0] rdata0_q, rdata0_d;
    logic [EXTRAM_DW-1:0] rdata1_q, rdata1_d;
    logic                 ready0_q, ready0_d;
    logic                 ready1_q, ready1_d;

    logic [1:0]           elig_s;
    logic                 gnt_valid_s;
    logic                 gnt_id_s;
    ext_req_t             m0_req_s, m1_req_s, sel_req_s;

    // A requester whose ready is currently showing has just completed and is not re-counted.
    assign elig_s    = {m1_valid & ~ready1_q, m0_valid & ~ready0_q};
    assign m0_req_s  = '{addr: m0_addr, wdata: m0_wdata, wstrb: m0_wstrb};
    assign m1_req_s  = '{addr: m1_addr, wdata: m1_wdata, wstrb: m1_wstrb};
    assign sel_req_s = (gnt_id_s == GNT_M1) ? m1_req_s : m0_req_s;

    rr_arb2 u_rr_arb2 (
        .req        (elig_s),
        .last_grant (last_q),
        .gnt_valid  (gnt_valid_s),
        .gnt_id     (gnt_id_s)
    );

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state: grant leaves IDLE, counter expiry leaves ACCESS, DONE lasts one cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (gnt_valid_s) begin
                    state_d = ST_ACCESS;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                if (cnt_q == {CW{1'b0}}) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_ACCESS;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Next values for the bus, counter, grant memory, read data and ready flops.
    always_comb begin
        cnt_d    = cnt_q;
        last_d   = last_q;
        a_d      = a_q;
        dout_d   = dout_q;
        wstrb_d  = wstrb_q;
        cs_d     = cs_q;
        oe_d     = oe_q;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
        ready0_d = 1'b0;
        ready1_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (gnt_valid_s) begin
                    a_d     = sel_req_s.addr;
                    dout_d  = sel_req_s.wdata;
                    wstrb_d = sel_req_s.wstrb;
                    cs_d    = 1'b1;
                    oe_d    = (sel_req_s.wstrb == 4'b0000);
                    cnt_d   = CNT_LOAD;
                    last_d  = gnt_id_s;
                end else begin
                    a_d     = {EXTRAM_AW{1'b0}};
                    dout_d  = {EXTRAM_DW{1'b0}};
                    wstrb_d = 4'b0000;
                    cs_d    = 1'b0;
                    oe_d    = 1'b0;
                end
            end
            ST_ACCESS: begin
                if (cnt_q != {CW{1'b0}}) begin
                    cnt_d = cnt_q - CW'(1'b1);
                end else begin
                    // Last access cycle: capture read data and release the bus.
                    if (oe_q && (last_q == GNT_M1)) begin
                        rdata1_d = extram_d_in;
                    end else if (oe_q) begin
                        rdata0_d = extram_d_in;
                    end else begin
                        rdata0_d = rdata0_q;
                        rdata1_d = rdata1_q;
                    end
                    if (last_q == GNT_M1) begin
                        ready1_d = 1'b1;
                    end else begin
                        ready0_d = 1'b1;
                    end
                    cs_d    = 1'b0;
                    oe_d    = 1'b0;
                    wstrb_d = 4'b0000;
                end
            end
            ST_DONE: begin
                cs_d    = 1'b0;
                oe_d    = 1'b0;
                wstrb_d = 4'b0000;
            end
            default: begin
                cs_d    = 1'b0;
                oe_d    = 1'b0;
                wstrb_d = 4'b0000;
            end
        endcase
    end

    // Datapath and output registers; reset drops the bus immediately and forgets any access.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q    <= {CW{1'b0}};
            last_q   <= GNT_M1;
            a_q      <= {EXTRAM_AW{1'b0}};
            dout_q   <= {EXTRAM_DW{1'b0}};
            wstrb_q  <= 4'b0000;
            cs_q     <= 1'b0;
            oe_q     <= 1'b0;
            rdata0_q <= {EXTRAM_DW{1'b0}};
            rdata1_q <= {EXTRAM_DW{1'b0}};
            ready0_q <= 1'b0;
            ready1_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            last_q   <= last_d;
            a_q      <= a_d;
            dout_q   <= dout_d;
            wstrb_q  <= wstrb_d;
            cs_q     <= cs_d;
            oe_q     <= oe_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
            ready0_q <= ready0_d;
            ready1_q <= ready1_d;
        end
    end

    assign m0_rdata     = rdata0_q;
    assign m1_rdata     = rdata1_q;
    assign m0_ready     = ready0_q;
    assign m1_ready     = ready1_q;
    assign extram_a     = a_q;
    assign extram_d_out = dout_q;
    assign extram_wstrb = wstrb_q;
    assign extram_cs    = cs_q;
    assign extram_oe    = oe_q;

endmodule
